// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the store buffer and its forwarding search.
// Ports: none (package).
// Holds the per-entry store record, the per-entry lifecycle state and the default widths.
package store_buffer_pkg;

    localparam int SB_FIFO_DEPTH = 8;
    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_AGE_WIDTH  = 32;

    // One buffered store. valid is set once address and data are known.
    typedef struct packed {
        logic                     valid;
        logic [SB_AGE_WIDTH-1:0]  age;
        logic [SB_ADDR_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
    } STORE_entry_t;

    typedef enum logic [1:0] {
        SB_FREE,
        SB_ALLOC,
        SB_READY,
        SB_COMMITTED
    } sb_state_t;

endpackage

// File: rtl/sb_forward_select.sv
// Combinational search for the youngest store older than a load that matches its address.
// Ports: load request in; per-entry state/age/addr arrays in; hit, stall and winning index out.
// Any older store whose address is still unknown forces a stall and suppresses the hit.
module sb_forward_select
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = SB_FIFO_DEPTH,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  ld_valid_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [31:0]           ld_age_i,
    input  sb_state_t             state_i [DEPTH],
    input  logic [31:0]           age_i   [DEPTH],
    input  logic [ADDR_WIDTH-1:0] addr_i  [DEPTH],
    output logic                  hit_o,
    output logic                  stall_o,
    output logic [IDX_W-1:0]      idx_o
);

    logic        stall_any;
    logic        found;
    logic [31:0] best_age;

    always_comb begin
        stall_any = 1'b0;
        found     = 1'b0;
        best_age  = '0;
        idx_o     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_i[i] != SB_FREE && age_i[i] < ld_age_i) begin
                if (state_i[i] == SB_ALLOC) begin
                    stall_any = 1'b1;
                end else if (addr_i[i] == ld_addr_i && (!found || age_i[i] > best_age)) begin
                    found    = 1'b1;
                    best_age = age_i[i];
                    idx_o    = IDX_W'(i);
                end
            end
        end
        hit_o   = ld_valid_i && found && !stall_any;
        stall_o = ld_valid_i && stall_any;
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at dispatch, fill at execute, commit at retire, drain to memory.
// Ports: alloc/exe/commit/flush control in; mem drain req/ack; load forwarding lookup; empty flag.
// Pointers carry a wrap bit so full (same index, different wrap) and empty (equal) are distinct.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH = SB_FIFO_DEPTH,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    localparam int IDX_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [31:0]           alloc_age,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_id,
    input  logic                  exe_valid,
    input  logic [IDX_W-1:0]      exe_id,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [DATA_WIDTH-1:0] exe_data,
    input  logic                  commit_valid,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ack,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_age,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic                  empty
);

    localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

    logic [IDX_W:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    sb_state_t       state_q [FIFO_DEPTH];
    sb_state_t       state_d [FIFO_DEPTH];
    STORE_entry_t    ent_q   [FIFO_DEPTH];
    STORE_entry_t    ent_d   [FIFO_DEPTH];

    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx, fwd_idx;
    logic             full, do_commit;
    logic [31:0]           ent_age  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ent_addr [FIFO_DEPTH];

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign full        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
    assign empty       = (head_q == tail_q);
    assign alloc_ready = !full;
    assign alloc_id    = tail_idx;

    // Drain straight from registers; address/data stay put until the head advances.
    assign mem_req  = (state_q[head_idx] == SB_COMMITTED);
    assign mem_addr = mem_req ? ent_q[head_idx].addr : '0;
    assign mem_data = mem_req ? ent_q[head_idx].data : '0;

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_age[i]  = ent_q[i].age;
            ent_addr[i] = ent_q[i].addr;
        end
    end

    sb_forward_select #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd (
        .ld_valid_i (ld_valid),
        .ld_addr_i  (ld_addr),
        .ld_age_i   (ld_age),
        .state_i    (state_q),
        .age_i      (ent_age),
        .addr_i     (ent_addr),
        .hit_o      (fwd_hit),
        .stall_o    (fwd_stall),
        .idx_o      (fwd_idx)
    );

    assign fwd_data = fwd_hit ? ent_q[fwd_idx].data : '0;

    always_comb begin
        head_d    = head_q;
        cmt_d     = cmt_q;
        tail_d    = tail_q;
        state_d   = state_q;
        ent_d     = ent_q;
        do_commit = commit_valid && (state_q[cmt_idx] == SB_READY);

        if (do_commit) begin
            state_d[cmt_idx] = SB_COMMITTED;
            cmt_d            = cmt_q + PTR_ONE;
        end

        if (mem_req && mem_ack) begin
            state_d[head_idx]     = SB_FREE;
            ent_d[head_idx].valid = 1'b0;
            head_d                = head_q + PTR_ONE;
        end

        if (flush) begin
            // The same-cycle commit has already moved its entry out of READY,
            // so only the speculative (uncommitted) entries are dropped here.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (state_d[i] == SB_ALLOC || state_d[i] == SB_READY) begin
                    state_d[i]     = SB_FREE;
                    ent_d[i].valid = 1'b0;
                end
            end
            tail_d = cmt_d;
        end else begin
            if (exe_valid && (state_q[exe_id] == SB_ALLOC || state_q[exe_id] == SB_READY)) begin
                ent_d[exe_id].addr  = exe_addr;
                ent_d[exe_id].data  = exe_data;
                ent_d[exe_id].valid = 1'b1;
                state_d[exe_id]     = SB_READY;
            end
            if (alloc_valid && alloc_ready) begin
                state_d[tail_idx] = SB_ALLOC;
                ent_d[tail_idx]   = '{valid: 1'b0, age: alloc_age, addr: '0, data: '0};
                tail_d            = tail_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                state_q[i] <= SB_FREE;
                ent_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            state_q <= state_d;
            ent_q   <= ent_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
// Ports: none (top-level bench).
// The model keeps stores as a program-ordered queue; ids are the queue position plus a base id.
module tb_store_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid, exe_valid, commit_valid, flush, mem_ack, ld_valid;
    logic [31:0] alloc_age, exe_addr, exe_data, ld_addr, ld_age;
    logic [2:0]  exe_id;
    logic        alloc_ready, mem_req, fwd_hit, fwd_stall, empty;
    logic [2:0]  alloc_id;
    logic [31:0] mem_addr, mem_data, fwd_data;

    store_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_age(alloc_age), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .exe_valid(exe_valid), .exe_id(exe_id), .exe_addr(exe_addr), .exe_data(exe_data),
        .commit_valid(commit_valid), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_age(ld_age),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned age;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exe;
        bit          cmt;
    } mstore_t;

    mstore_t     mq[$];
    int          base_id;
    int unsigned age_ctr;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int n_committed();
        int n = 0;
        while (n < mq.size() && mq[n].cmt) n++;
        return n;
    endfunction

    task automatic idle();
        alloc_valid = 0; alloc_age = 0; exe_valid = 0; exe_id = 0; exe_addr = 0; exe_data = 0;
        commit_valid = 0; flush = 0; mem_ack = 0; ld_valid = 0; ld_addr = 0; ld_age = 0;
    endtask

    // Compare every output against what the queue model says for the current inputs.
    task automatic compare_all();
        bit exp_req, st, found;
        int unsigned bage;
        logic [31:0] bdata;
        exp_req = mq.size() > 0 && mq[0].cmt;
        chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
        chk("alloc_id", alloc_id, (base_id + mq.size()) % DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("mem_req", mem_req, exp_req);
        if (exp_req) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            chk("mem_data", mem_data, mq[0].data);
        end
        st = 0; found = 0; bage = 0; bdata = 0;
        if (ld_valid) begin
            foreach (mq[i]) begin
                if (mq[i].age < ld_age) begin
                    if (!mq[i].exe) st = 1;
                    else if (mq[i].addr == ld_addr && (!found || mq[i].age > bage)) begin
                        found = 1; bage = mq[i].age; bdata = mq[i].data;
                    end
                end
            end
        end
        chk("fwd_stall", fwd_stall, st);
        chk("fwd_hit", fwd_hit, found && !st);
        chk("fwd_data", fwd_data, (found && !st) ? bdata : 32'h0);
    endtask

    task automatic model_update();
        int  nc, p;
        bit  do_alloc, do_commit, do_drain;
        nc        = n_committed();
        do_alloc  = alloc_valid && mq.size() < DEPTH && !flush;
        do_commit = commit_valid && nc < mq.size() && mq[nc].exe;
        do_drain  = mq.size() > 0 && mq[0].cmt && mem_ack;
        if (!flush && exe_valid) begin
            p = (int'(exe_id) - base_id + DEPTH) % DEPTH;
            if (p < mq.size() && !mq[p].cmt) begin
                mq[p].exe = 1; mq[p].addr = exe_addr; mq[p].data = exe_data;
            end
        end
        if (do_commit) begin
            mq[nc].cmt = 1;
            nc++;
        end
        if (flush) while (mq.size() > nc) void'(mq.pop_back());
        if (do_alloc) mq.push_back('{age: alloc_age, addr: 0, data: 0, exe: 0, cmt: 0});
        if (do_drain) begin
            void'(mq.pop_front());
            base_id = (base_id + 1) % DEPTH;
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        mq.delete();
        base_id = 0;
        rst_n = 1;
    endtask

    task automatic gen_random();
        int pos[$];
        idle();
        alloc_valid = 1'($urandom % 2);
        if (alloc_valid) begin
            age_ctr++;
            alloc_age = age_ctr;
        end
        foreach (mq[i]) if (!mq[i].exe) pos.push_back(i);
        if (pos.size() > 0 && ($urandom % 2) == 0) begin
            exe_valid = 1;
            exe_id    = 3'((base_id + pos[$urandom % pos.size()]) % DEPTH);
            exe_addr  = 32'h40 + 32'(4 * ($urandom % 4));
            exe_data  = $urandom;
        end
        if (n_committed() < mq.size() && mq[n_committed()].exe && ($urandom % 3) == 0)
            commit_valid = 1;
        mem_ack  = 1'($urandom % 2);
        flush    = ($urandom % 16) == 0;
        ld_valid = 1'($urandom % 2);
        ld_addr  = 32'h40 + 32'(4 * ($urandom % 4));
        ld_age   = $urandom_range(age_ctr + 2, 0);
    endtask

    initial begin
        idle();
        age_ctr = 100;
        do_reset();

        // Reset state.
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_empty", empty, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_stall", fwd_stall, 0);

        // Fill all 8 entries without committing.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); alloc_valid = 1; alloc_age = 32'(i + 1);
            #1 chk("fill_id", alloc_id, i);
            tick();
        end
        idle();
        #1 chk("fill_full_ready", alloc_ready, 0);
        chk("fill_empty", empty, 0);
        alloc_valid = 1; alloc_age = 9;
        tick();   // rejected while full
        idle(); flush = 1;
        tick();   // nothing committed: buffer drains to empty
        idle();
        #1 chk("flush_all_empty", empty, 1);

        // Single drain with mem_ack held off.
        do_reset();
        idle(); alloc_valid = 1; alloc_age = 1; tick();
        idle(); exe_valid = 1; exe_id = 0; exe_addr = 32'h100; exe_data = 32'hDEAD; tick();
        idle(); commit_valid = 1; tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            #1;
            chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, 32'h100);
            chk("hold_data", mem_data, 32'hDEAD);
            tick();
        end
        idle(); mem_ack = 1; tick();
        idle();
        #1 chk("drained_empty", empty, 1);

        // Store-to-load forwarding.
        do_reset();
        idle(); alloc_valid = 1; alloc_age = 2; tick();
        idle(); alloc_valid = 1; alloc_age = 5; tick();
        idle(); exe_valid = 1; exe_id = 0; exe_addr = 32'h40; exe_data = 32'h11; tick();
        idle(); exe_valid = 1; exe_id = 1; exe_addr = 32'h40; exe_data = 32'h22; tick();
        idle(); ld_valid = 1; ld_addr = 32'h40; ld_age = 7;
        #1 chk("fwd7_hit", fwd_hit, 1); chk("fwd7_data", fwd_data, 32'h22); tick();
        ld_valid = 1; ld_addr = 32'h40; ld_age = 4;
        #1 chk("fwd4_hit", fwd_hit, 1); chk("fwd4_data", fwd_data, 32'h11); tick();
        ld_valid = 1; ld_addr = 32'h40; ld_age = 1;
        #1 chk("fwd1_hit", fwd_hit, 0); tick();
        idle(); alloc_valid = 1; alloc_age = 3; tick();
        idle(); ld_valid = 1; ld_addr = 32'h80; ld_age = 6;
        #1 chk("stall_stall", fwd_stall, 1); chk("stall_hit", fwd_hit, 0); tick();

        // Flush keeps committed stores and rewinds tail to the commit pointer.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); alloc_valid = 1; alloc_age = 32'(i + 1); tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle(); exe_valid = 1; exe_id = 3'(i); exe_addr = 32'h200 + 32'(i * 4); exe_data = 32'(i + 7); tick();
        end
        idle(); commit_valid = 1; tick();
        idle(); commit_valid = 1; tick();
        idle(); flush = 1; tick();
        idle();
        #1 chk("flush_alloc_id", alloc_id, 2); chk("flush_not_empty", empty, 0);
        idle(); mem_ack = 1; tick();
        #1 chk("flush_drain2_addr", mem_addr, 32'h204);
        tick();
        idle();
        #1 chk("flush_drained", empty, 1);

        // Wrap-around: 20 full lifecycles, then fill from a wrapped position.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle(); alloc_valid = 1; alloc_age = 32'(i + 1);
            #1 chk("wrap_id", alloc_id, i % DEPTH);
            tick();
            idle(); exe_valid = 1; exe_id = 3'(i % DEPTH); exe_addr = 32'(i); exe_data = 32'(i * 3); tick();
            idle(); commit_valid = 1; tick();
            idle(); mem_ack = 1; tick();
            idle();
            #1 chk("wrap_empty", empty, 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); alloc_valid = 1; alloc_age = 32'(100 + i); tick();
        end
        idle();
        #1 chk("wrap_full", alloc_ready, 0); chk("wrap_full_id", alloc_id, 4);

        // Asynchronous reset while a drain is pending.
        do_reset();
        idle(); alloc_valid = 1; alloc_age = 1; tick();
        idle(); exe_valid = 1; exe_id = 0; exe_addr = 32'h300; exe_data = 32'h5; tick();
        idle(); commit_valid = 1; tick();
        idle();
        #1 chk("pre_rst_req", mem_req, 1);
        #1 rst_n = 0;
        #1 chk("async_rst_req", mem_req, 0); chk("async_rst_empty", empty, 1);
        @(negedge clk);
        mq.delete(); base_id = 0;
        rst_n = 1;

        // Randomized traffic against the model.
        age_ctr = 1000;
        for (int c = 0; c < 3000; c++) begin
            gen_random();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order circular buffer of STORE_entry_t between dispatch/execute and data memory.
- Allocates a store_id at dispatch, which is recorded in the ROB_ENTRY_t store_id field.
- Captures address and data when the store executes, marks the entry committed when the ROB retires it, and drains committed entries to memory in order.
- Provides store-to-load forwarding and stall for the load path; discards uncommitted entries on flush.

Parameters:
- FIFO_DEPTH, 8, number of entries; power of two, ≥2; store_id width = $clog2(FIFO_DEPTH)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, store data width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_age  in  32  program-order age of the store
- alloc_ready  out  1  buffer not full
- alloc_id  out  $clog2(FIFO_DEPTH)  id granted; equals the tail pointer
- exe_valid  in  1  store address/data resolved
- exe_id  in  $clog2(FIFO_DEPTH)  entry to write
- exe_addr  in  ADDR_WIDTH  store address
- exe_data  in  DATA_WIDTH  store data
- commit_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  mispredict recovery
- mem_req  out  1  drain request
- mem_addr  out  ADDR_WIDTH  drain address
- mem_data  out  DATA_WIDTH  drain data
- mem_ack  in  1  memory accepted the request
- ld_valid  in  1  load lookup
- ld_addr  in  ADDR_WIDTH  load address
- ld_age  in  32  load age
- fwd_hit  out  1  forwarded data valid
- fwd_data  out  DATA_WIDTH  forwarded data
- fwd_stall  out  1  load must retry
- empty  out  1  no occupied entries

Behaviour:
- Pointers head, cmt, tail, each $clog2(FIFO_DEPTH)+1 bits (wrap bit).
  - Occupied = tail − head. Full when the index bits are equal and the wrap bits differ.
  - Invariant: head ≤ cmt ≤ tail in ring order.
- Per-entry state: FREE, ALLOC (STORE_entry_t.valid=0), READY (valid=1), COMMITTED.
- Reset: all pointers 0, all entries FREE, valid=0. Outputs: alloc_ready=1, alloc_id=0, mem_req=0, fwd_hit=0, fwd_stall=0, empty=1, mem_addr/mem_data/fwd_data=0.
- Alloc:
  - Accepted when alloc_valid && alloc_ready.
  - alloc_id is combinational from tail.
  - Entry becomes ALLOC with age stored; tail++ next edge.
- Exe:
  - On exe_valid, the entry exe_id takes addr/data and valid=1 next edge.
  - exe_id of a FREE entry is ignored; the bench asserts it never occurs.
- Commit:
  - Entry at cmt must be READY (assertion).
  - Entry becomes COMMITTED; cmt++.
  - At most one commit per cycle.
- Drain:
  - mem_req = entry[head] COMMITTED, driven combinationally from registers.
  - mem_addr/mem_data are held stable until mem_ack.
  - On mem_req && mem_ack: entry FREE, head++.
  - Drain throughput is one entry per cycle.
- Flush:
  - Next edge: tail ← cmt; entries between cmt and the old tail become FREE.
  - COMMITTED entries and the drain are unaffected.
  - Flush has priority over alloc and exe in the same cycle; those are dropped.
  - A commit in the same cycle as flush is applied first, so tail ← cmt+1.
- Simultaneous alloc and drain when full: alloc_ready reflects the current state only. No bypass, so the alloc stalls for one cycle.
- Forwarding is combinational over all non-FREE entries with age < ld_age:
  - Any such entry in ALLOC state → fwd_stall=1, fwd_hit=0.
  - Otherwise the youngest such entry (max age) with addr == ld_addr → fwd_hit=1, fwd_data=its data.
  - No match → both 0.
  - Matching is on the full address; word-granular only.
  - When ld_valid=0, both outputs are 0.
- Age comparison is unsigned 32-bit; wrap is not supported.
- Asynchronous reset mid-drain abandons the request: mem_req drops immediately.

Decomposition:
- Shared package holds:
  - STORE_entry_t (existing).
  - New enum sb_state_t {SB_FREE, SB_ALLOC, SB_READY, SB_COMMITTED}.
  - FIFO_DEPTH from parameter_pkg.
- One sub-module, sb_forward_select: combinational youngest-older-match search returning hit/stall/index.

Test Plan:
- Reset, then alloc 8 stores (ages 1..8) with no commits → alloc_id 0..7, alloc_ready=0 after the 8th, empty=0.
- Alloc id0, exe addr=0x100 data=0xDEAD, commit, mem_ack held low 3 cycles → mem_req=1 with 0x100/0xDEAD stable all 3 cycles; ack → empty=1 next cycle.
- Stores age 2 @0x40=0x11 and age 5 @0x40=0x22, both READY; load age 7 @0x40 → fwd_hit=1, fwd_data=0x22. Load age 4 → fwd_data=0x11. Load age 1 → hit=0.
- Store age 3 allocated but not executed; load age 6 to any address → fwd_stall=1, fwd_hit=0.
- 4 allocs, commit 2, flush → tail=cmt=2, next alloc_id=2; the 2 committed entries still drain.
- Wrap: 20 alloc/exe/commit/ack sequences at depth 8 → ids cycle 0..7,0..; full/empty flags are correct at each boundary.
